// File: rtl/sensor_request_controller.sv
// Command-frame controller: collects a 2-byte request from UART RX, runs one sensor
// decoder transaction with timeout, and returns a 2-byte response via UART TX.
module sensor_request_controller #(
    parameter int TIMEOUT_CYCLES   = 50_000_000,
    parameter int INTERBYTE_CYCLES = 5_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       sensor_enable,
    output logic [7:0] sensor_request,
    output logic [4:0] sensor_address,
    input  logic [7:0] sensor_data,
    input  logic       sensor_finished,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       busy
);

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int IB_W = (INTERBYTE_CYCLES > 2) ? $clog2(INTERBYTE_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IB_W-1:0] IB_LAST = IB_W'(INTERBYTE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_REQUEST,
        ST_WAIT_FIN,
        ST_TX0,
        ST_TXW0,
        ST_TX1,
        ST_TXW1
    } state_t;

    state_t          state;
    logic [7:0]      code_reg;
    logic [7:0]      resp0;
    logic [7:0]      resp1;
    logic [TO_W-1:0] to_count;
    logic [IB_W-1:0] ib_count;
    logic            tx_guard;

    // busy is updated alongside each transition so it follows the state being entered
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            code_reg       <= '0;
            resp0          <= '0;
            resp1          <= '0;
            to_count       <= '0;
            ib_count       <= '0;
            tx_guard       <= 1'b0;
            sensor_enable  <= 1'b0;
            sensor_request <= '0;
            sensor_address <= '0;
            tx_data        <= '0;
            tx_start       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            sensor_enable <= 1'b0;
            tx_start      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (rx_done) begin
                        code_reg <= rx_data;
                        ib_count <= '0;
                        state    <= ST_GET_ADDR;
                    end
                end
                ST_GET_ADDR: begin
                    if (rx_done) begin
                        busy <= 1'b1;
                        if (rx_data[7:5] == 3'b000) begin
                            sensor_address <= rx_data[4:0];
                            state          <= ST_REQUEST;
                        end else begin
                            resp0 <= 8'hFF;
                            resp1 <= 8'h00;
                            state <= ST_TX0;
                        end
                    end else if (ib_count == IB_LAST) begin
                        state <= ST_IDLE;
                    end else if (ib_count != '1) begin
                        ib_count <= ib_count + IB_W'(1);
                    end
                end
                ST_REQUEST: begin
                    sensor_request <= code_reg;
                    sensor_enable  <= 1'b1;
                    to_count       <= '0;
                    state          <= ST_WAIT_FIN;
                end
                ST_WAIT_FIN: begin
                    // a completion in the same cycle as the last timeout count still wins
                    if (sensor_finished) begin
                        resp0 <= sensor_request;
                        resp1 <= sensor_data;
                        state <= ST_TX0;
                    end else if (to_count == TO_LAST) begin
                        resp0 <= 8'hFE;
                        resp1 <= 8'h00;
                        state <= ST_TX0;
                    end else if (to_count != '1) begin
                        to_count <= to_count + TO_W'(1);
                    end
                end
                ST_TX0: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= resp0;
                        tx_guard <= 1'b1;
                        state    <= ST_TXW0;
                    end
                end
                ST_TXW0: begin
                    if (tx_guard) begin
                        tx_guard <= 1'b0;
                    end else if (!tx_busy) begin
                        state <= ST_TX1;
                    end
                end
                ST_TX1: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= resp1;
                        tx_guard <= 1'b1;
                        state    <= ST_TXW1;
                    end
                end
                ST_TXW1: begin
                    if (tx_guard) begin
                        tx_guard <= 1'b0;
                    end else if (!tx_busy) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_request_controller.sv
// Bench for sensor_request_controller: directed vector table, hand-written corner
// sequences and randomized frames checked against a frame-level response model.
module tb_sensor_request_controller;

    localparam int T  = 100;
    localparam int IB = 20;

    logic       clock;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       sensor_enable;
    logic [7:0] sensor_request;
    logic [4:0] sensor_address;
    logic [7:0] sensor_data;
    logic       sensor_finished;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       busy;

    sensor_request_controller #(
        .TIMEOUT_CYCLES  (T),
        .INTERBYTE_CYCLES(IB)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_done        (rx_done),
        .sensor_enable  (sensor_enable),
        .sensor_request (sensor_request),
        .sensor_address (sensor_address),
        .sensor_data    (sensor_data),
        .sensor_finished(sensor_finished),
        .tx_data        (tx_data),
        .tx_start       (tx_start),
        .tx_busy        (tx_busy),
        .busy           (busy)
    );

    typedef struct {
        logic [7:0] code;
        logic [7:0] addr;
        int         gap;
        int         fin_delay;
        logic [7:0] data;
        logic [7:0] exp_b0;
        logic [7:0] exp_b1;
        int         exp_en;
        int         exp_lat;
    } vec_t;

    vec_t       vecs[10];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] txq[$];
    int         tx_cyc_q[$];
    int         enable_count = 0;
    int         en_cyc = 0;
    logic [7:0] cap_req = 0;
    logic [4:0] cap_addr = 0;
    logic       frame_en = 0;
    int         stab_err = 0;
    int         tx_hold = 0;
    logic       force_busy = 0;
    int         tx_len = 4;

    logic [7:0] r_code, r_addr, r_data, m_b0, m_b1;
    int         r_gap, r_d, m_en, m_lat, base, en_base, early, waited;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor plus UART TX model: logs transmitted bytes and enable pulses, drives tx_busy
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) frame_en = 1'b0;
            if (sensor_enable) begin
                enable_count++;
                en_cyc   = cyc;
                cap_req  = sensor_request;
                cap_addr = sensor_address;
                frame_en = 1'b1;
            end
            if (tx_start) begin
                txq.push_back(tx_data);
                tx_cyc_q.push_back(cyc);
                if (frame_en && (sensor_request != cap_req || sensor_address != cap_addr))
                    stab_err++;
                tx_hold = tx_len;
            end
            if (force_busy || tx_hold > 0) begin
                tx_busy = 1'b1;
                if (tx_hold > 0) tx_hold--;
            end else begin
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clock);
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic wait_tx(input int first, input int n);
        waited = 0;
        while (txq.size() < first + n && waited < T + 300) begin
            @(negedge clock);
            waited++;
        end
        repeat (8) @(negedge clock);
    endtask

    // Response model: decides the reply purely from the frame contents and completion delay
    function automatic void model(input logic [7:0] code, input logic [7:0] addr, input int d,
                                  input logic [7:0] data, output logic [7:0] b0,
                                  output logic [7:0] b1, output int en, output int lat);
        if (addr[7:5] != 3'b000) begin
            b0 = 8'hFF; b1 = 8'h00; en = 0; lat = 0;
        end else if (d >= 1 && d <= T) begin
            b0 = code; b1 = data; en = 1; lat = d + 1;
        end else begin
            b0 = 8'hFE; b1 = 8'h00; en = 1; lat = T + 1;
        end
    endfunction

    task automatic apply_stimulus(input string tag, input logic [7:0] code, input logic [7:0] addr,
                                  input int gap, input int d, input logic [7:0] data,
                                  input logic [7:0] exp_b0, input logic [7:0] exp_b1,
                                  input int exp_en, input int exp_lat);
        int first, ebase;
        first = txq.size();
        ebase = enable_count;
        send_byte(code);
        repeat (gap) @(negedge clock);
        send_byte(addr);
        @(negedge clock);
        check_output({tag, " enable timing"}, int'(sensor_enable), exp_en);
        check_output({tag, " busy after addr"}, int'(busy), 1);
        if (d > 0) begin
            repeat (d - 1) @(negedge clock);
            sensor_data     = data;
            sensor_finished = 1'b1;
            @(negedge clock);
            sensor_finished = 1'b0;
            sensor_data     = 8'($urandom);
        end
        wait_tx(first, 2);
        check_output({tag, " tx count"}, txq.size() - first, 2);
        if (txq.size() >= first + 2) begin
            check_output({tag, " tx byte0"}, int'(txq[first]), int'(exp_b0));
            check_output({tag, " tx byte1"}, int'(txq[first + 1]), int'(exp_b1));
            if (exp_lat > 0)
                check_output({tag, " tx latency"}, tx_cyc_q[first] - en_cyc, exp_lat);
        end
        check_output({tag, " enable pulses"}, enable_count - ebase, exp_en);
        if (exp_en != 0) begin
            check_output({tag, " request"}, int'(cap_req), int'(code));
            check_output({tag, " address"}, int'(cap_addr), int'(addr[4:0]));
        end
        check_output({tag, " busy idle"}, int'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{8'h01, 8'h00, 2,  40,  8'h19, 8'h01, 8'h19, 1, 41};
        vecs[1] = '{8'h03, 8'h25, 1,  0,   8'h00, 8'hFF, 8'h00, 0, 0};
        vecs[2] = '{8'h02, 8'h04, 0,  0,   8'h00, 8'hFE, 8'h00, 1, 101};
        vecs[3] = '{8'h7A, 8'h1F, 18, 100, 8'hC3, 8'h7A, 8'hC3, 1, 101};
        vecs[4] = '{8'h55, 8'h0A, 3,  101, 8'hAA, 8'hFE, 8'h00, 1, 101};
        vecs[5] = '{8'h02, 8'h04, 0,  150, 8'h5C, 8'hFE, 8'h00, 1, 101};
        vecs[6] = '{8'h00, 8'h20, 5,  0,   8'h00, 8'hFF, 8'h00, 0, 0};
        vecs[7] = '{8'hFF, 8'hE0, 0,  0,   8'h00, 8'hFF, 8'h00, 0, 0};
        vecs[8] = '{8'h80, 8'h11, 4,  1,   8'h5A, 8'h80, 8'h5A, 1, 2};
        vecs[9] = '{8'h00, 8'h1F, 0,  7,   8'h00, 8'h00, 8'h00, 1, 8};

        reset = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        sensor_data = 8'h00;
        sensor_finished = 1'b0;
        repeat (3) @(negedge clock);
        check_output("reset sensor_enable", int'(sensor_enable), 0);
        check_output("reset tx_start", int'(tx_start), 0);
        check_output("reset busy", int'(busy), 0);
        check_output("reset sensor_request", int'(sensor_request), 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 10; i++)
            apply_stimulus($sformatf("vec%0d", i), vecs[i].code, vecs[i].addr, vecs[i].gap,
                           vecs[i].fin_delay, vecs[i].data, vecs[i].exp_b0, vecs[i].exp_b1,
                           vecs[i].exp_en, vecs[i].exp_lat);

        // Lone first byte: the partial frame must be discarded silently
        base = txq.size();
        en_base = enable_count;
        send_byte(8'h01);
        repeat (25) @(negedge clock);
        check_output("interbyte no tx", txq.size() - base, 0);
        check_output("interbyte no enable", enable_count - en_base, 0);
        check_output("interbyte busy", int'(busy), 0);
        apply_stimulus("after interbyte", 8'h04, 8'h01, 2, 10, 8'h6E, 8'h04, 8'h6E, 1, 11);

        // Backpressure at response time plus a stray rx byte during the decoder wait
        base = txq.size();
        en_base = enable_count;
        send_byte(8'h11);
        send_byte(8'h05);
        @(negedge clock);
        repeat (4) @(negedge clock);
        send_byte(8'h09);
        force_busy = 1'b1;
        repeat (20) @(negedge clock);
        sensor_data = 8'h77;
        sensor_finished = 1'b1;
        @(negedge clock);
        sensor_finished = 1'b0;
        early = 0;
        repeat (30) begin
            @(negedge clock);
            if (tx_start) early++;
        end
        force_busy = 1'b0;
        check_output("backpressure tx_start while busy", early, 0);
        wait_tx(base, 2);
        check_output("backpressure tx count", txq.size() - base, 2);
        if (txq.size() >= base + 2) begin
            check_output("backpressure byte0", int'(txq[base]), 8'h11);
            check_output("backpressure byte1", int'(txq[base + 1]), 8'h77);
            check_output("backpressure byte spacing", int'(tx_cyc_q[base + 1] - tx_cyc_q[base] >= 2), 1);
        end
        check_output("backpressure enables", enable_count - en_base, 1);
        check_output("backpressure busy idle", int'(busy), 0);
        apply_stimulus("after drop", 8'h42, 8'h07, 3, 12, 8'h99, 8'h42, 8'h99, 1, 13);

        // Async reset while waiting for the decoder
        base = txq.size();
        send_byte(8'h21);
        send_byte(8'h02);
        @(negedge clock);
        check_output("reset-seq enable", int'(sensor_enable), 1);
        repeat (20) @(negedge clock);
        reset = 1'b0;
        #1;
        check_output("async reset sensor_enable", int'(sensor_enable), 0);
        check_output("async reset sensor_request", int'(sensor_request), 0);
        check_output("async reset sensor_address", int'(sensor_address), 0);
        check_output("async reset tx_data", int'(tx_data), 0);
        check_output("async reset tx_start", int'(tx_start), 0);
        check_output("async reset busy", int'(busy), 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (T + 50) @(negedge clock);
        check_output("no tx after reset", txq.size() - base, 0);
        check_output("idle after reset", int'(busy), 0);

        for (int i = 0; i < 20; i++) begin
            r_code = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                r_addr = {3'($urandom_range(1, 7)), 5'($urandom)};
            else
                r_addr = {3'b000, 5'($urandom)};
            r_gap  = $urandom_range(0, 15);
            r_d    = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, T + 8);
            r_data = 8'($urandom);
            model(r_code, r_addr, r_d, r_data, m_b0, m_b1, m_en, m_lat);
            apply_stimulus($sformatf("rand%0d", i), r_code, r_addr, r_gap, r_d, r_data,
                           m_b0, m_b1, m_en, m_lat);
        end

        check_output("request/address stability", stab_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sensor_request_controller.md
# sensor_request_controller

Command-frame controller between the UART receiver/transmitter and the sensor decoder. Collects a 2-byte command (request code, sensor address) from the UART RX byte stream, starts one decoder transaction, and waits for its completion or a timeout. It then returns a 2-byte response (echoed code or error status, data byte) through the UART TX handshake. It owns all request sequencing so the decoder only ever sees a stable request and a single enable pulse.

## Interface
- `TIMEOUT_CYCLES`, default 50_000_000: max cycles to wait for `sensor_finished` after the enable pulse (1 s at 50 MHz).
- `INTERBYTE_CYCLES`, default 5_000_000: max cycles between command byte 0 and byte 1 before the partial frame is discarded.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid only while `rx_done` is high.
- `rx_done`  in  1  one-cycle pulse per received byte.
- `sensor_enable`  out  1  one-cycle start pulse to the decoder.
- `sensor_request`  out  8  request code to the decoder; stable from the enable pulse until the response is sent.
- `sensor_address`  out  5  selected sensor (0–31); same stability rule as `sensor_request`.
- `sensor_data`  in  8  decoder result; valid in the cycle `sensor_finished` is high.
- `sensor_finished`  in  1  one-cycle decoder completion pulse.
- `tx_data`  out  8  byte to transmit; valid while `tx_start` is high.
- `tx_start`  out  1  one-cycle transmit request.
- `tx_busy`  in  1  transmitter busy; rises the cycle after `tx_start`.
- `busy`  out  1  high in every state except IDLE and GET_ADDR.

## Operation
- Command frame: byte 0 is the request code, byte 1 is the address. Address bits [7:5] must be 0.
- Response frame:
  - Normal: byte 0 = request code echo, byte 1 = `sensor_data`.
  - Invalid address: 0xFF, 0x00.
  - Timeout: 0xFE, 0x00.
- States and transitions:
  - IDLE: on `rx_done`, latch `rx_data` into the code register, clear the interbyte counter, go to GET_ADDR.
  - GET_ADDR:
    - On `rx_done` with `rx_data[7:5]==0`: latch `rx_data[4:0]` into `sensor_address`, go to REQUEST.
    - On `rx_done` with `rx_data[7:5]!=0`: load response 0xFF/0x00, go to TX0.
    - Else count. When the count reaches `INTERBYTE_CYCLES-1`, return to IDLE silently.
  - REQUEST: drive `sensor_request` from the code register, assert `sensor_enable` for exactly this cycle, clear the timeout counter, go to WAIT.
  - WAIT:
    - On `sensor_finished`: latch `sensor_data`, load response code/data, go to TX0.
    - Else count. When the count reaches `TIMEOUT_CYCLES-1`, load 0xFE/0x00 and go to TX0.
  - TX0: when `tx_busy==0`, pulse `tx_start` with `tx_data` = response byte 0, go to TXW0.
  - TXW0: ignore `tx_busy` in the first cycle (guard), then wait for `tx_busy==0`, go to TX1.
  - TX1 / TXW1: same as TX0 / TXW0 with response byte 1. Exit to IDLE.
- `rx_done` in any state other than IDLE/GET_ADDR is dropped; there is no queueing.
- `sensor_finished` outside WAIT is ignored. This covers a late completion after a timeout.
- Counters are sized `$clog2` of their parameter. They saturate, never wrap.
- Any undefined state encoding returns to IDLE.

## Timing
- Reset (async assert, sync release), all outputs 0:
  - `sensor_enable`, `sensor_request`, `sensor_address`, `tx_data`, `tx_start`, `busy` = 0.
  - State = IDLE; counters = 0.
- Reset asserted mid-transaction aborts immediately. No response byte is sent after release.
- `rx_done` for byte 1 sampled at edge n → `sensor_enable` high for the cycle after edge n+1, `busy` high from that cycle.
- `sensor_finished` sampled at edge m → `tx_start` high for the cycle after edge m+1, if `tx_busy` is 0.
- Response byte 1 `tx_start` follows at least 2 cycles after byte 0's `tx_start`, and only after `tx_busy` falls.
- Timeout response: `tx_start` asserted `TIMEOUT_CYCLES`+1 cycles after the enable pulse.
- `sensor_request`/`sensor_address` are unchanged from REQUEST until the return to IDLE.

## Test plan
- Normal read: rx 0x01, 0x00; decoder returns `sensor_data`=0x19 with `sensor_finished` 40 cycles later → one `sensor_enable` pulse, address 0, tx 0x01 then 0x19, `busy` low after the TXW1 exit.
- Invalid address: rx 0x03, 0x25 → no `sensor_enable`; tx 0xFF then 0x00.
- Decoder timeout (`TIMEOUT_CYCLES`=100): rx 0x02, 0x04, no finished → tx 0xFE, 0x00 at enable+101 cycles. A finished pulse injected at cycle 150 is ignored.
- Interbyte timeout (`INTERBYTE_CYCLES`=20): rx 0x01 only → return to IDLE at cycle 20, no tx. Next frame 0x04, 0x01 → tx 0x04, data.
- Backpressure and drops: `tx_busy` held high 30 cycles at response time, and an extra rx byte arrives during WAIT → `tx_start` waits for `tx_busy` low, the extra byte produces no effect.
- Async reset asserted in WAIT → all outputs 0 immediately; no tx after release.
